// File: rtl/clr_sdp_ram_pkg.sv
// Shared definitions for the self-clearing simple dual-port RAM: controller
// state encoding and read-during-write mode selectors.
package clr_sdp_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

endpackage

// File: rtl/clr_sdp_ram_ctrl.sv
// Clear sequencer: sweeps every address once after reset or clear_req,
// then holds READY until the next clear_req.
module clr_sdp_ram_ctrl
    import clr_sdp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear_req,
    output logic                  ready,
    output logic                  sweep_we,
    output logic [ADDR_WIDTH-1:0] sweep_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // clear_req is only honoured in READY; a request during a sweep is dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    assign ready      = (state_q == ST_READY);
    assign sweep_we   = (state_q == ST_CLEAR);
    assign sweep_addr = cnt_q;

endmodule

// File: rtl/clr_sdp_ram.sv
// Simple dual-port RAM with byte-lane writes, selectable read-during-write
// behaviour, optional output register and a hardware clear sweep.
module clr_sdp_ram
    import clr_sdp_ram_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 10,
    parameter int                    BYTE_WIDTH  = 8,
    parameter int                    RDW_MODE    = 0,
    parameter int                    OUT_REG     = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             clear_req,
    output logic                             ready,
    input  logic                             we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
    input  logic [ADDR_WIDTH-1:0]            write_addr,
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic                             re,
    input  logic [ADDR_WIDTH-1:0]            read_addr,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic                             data_out_valid
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int NUM_LANES = DATA_WIDTH / BYTE_WIDTH;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("clr_sdp_ram: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    logic                  sweep_we;
    logic [ADDR_WIDTH-1:0] sweep_addr;

    clr_sdp_ram_ctrl #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ctrl (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_req (clear_req),
        .ready     (ready),
        .sweep_we  (sweep_we),
        .sweep_addr(sweep_addr)
    );

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] rd_word;

    assign wr_en = ready & we;
    assign rd_en = ready & re;

    // merged_word is what the write address holds after this edge; it is only
    // returned to the reader when forwarding new data on an address collision.
    always_comb begin
        merged_word = mem[write_addr];
        for (int i = 0; i < NUM_LANES; i++) begin
            if (be[i]) begin
                merged_word[i*BYTE_WIDTH +: BYTE_WIDTH] = data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        rd_word = mem[read_addr];
        if (RDW_MODE == RDW_NEW && wr_en && (write_addr == read_addr)) begin
            rd_word = merged_word;
        end
    end

    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[sweep_addr] <= CLEAR_VALUE;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (be[i]) begin
                    mem[write_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Stage p1: array read, held between accepted reads.
    logic [DATA_WIDTH-1:0] rd_data_p1_q, rd_data_p1_d;
    logic                  vld_p1_q, vld_p1_d;

    always_comb begin
        vld_p1_d     = rd_en;
        rd_data_p1_d = rd_en ? rd_word : rd_data_p1_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p1_q     <= 1'b0;
            rd_data_p1_q <= '0;
        end else begin
            vld_p1_q     <= vld_p1_d;
            rd_data_p1_q <= rd_data_p1_d;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        // Stage p2: optional output register.
        logic [DATA_WIDTH-1:0] rd_data_p2_q, rd_data_p2_d;
        logic                  vld_p2_q, vld_p2_d;

        always_comb begin
            vld_p2_d     = vld_p1_q;
            rd_data_p2_d = vld_p1_q ? rd_data_p1_q : rd_data_p2_q;
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                vld_p2_q     <= 1'b0;
                rd_data_p2_q <= '0;
            end else begin
                vld_p2_q     <= vld_p2_d;
                rd_data_p2_q <= rd_data_p2_d;
            end
        end

        assign data_out       = rd_data_p2_q;
        assign data_out_valid = vld_p2_q;
    end else begin : g_no_out_reg
        assign data_out       = rd_data_p1_q;
        assign data_out_valid = vld_p1_q;
    end

endmodule

// File: tb/tb_clr_sdp_ram.sv
// Directed bench for clr_sdp_ram: two instances (old-data/no output register,
// new-data/output register) driven by the same stimulus.
module tb_clr_sdp_ram;

    localparam logic [31:0] CV0 = 32'h0000_0000;
    localparam logic [31:0] CV1 = 32'hA5A5_5A5A;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear_req;
    logic        we;
    logic [3:0]  be;
    logic [3:0]  write_addr;
    logic [31:0] data_in;
    logic        re;
    logic [3:0]  read_addr;
    logic        rdy0, rdy1, vld0, vld1;
    logic [31:0] dout0, dout1;

    int tests = 0;
    int fails = 0;

    // Bench model: expected memory contents and expected output pipelines.
    logic [31:0] exp0 [16];
    logic [31:0] exp1 [16];
    logic        m_ready = 1'b0;
    logic        e0_vld = 1'b0, e1a_vld = 1'b0, e1_vld = 1'b0;
    logic [31:0] e0_dat = '0, e1a_dat = '0, e1_dat = '0;
    string       step = "reset";

    always #5 clk = ~clk;

    clr_sdp_ram #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
        .RDW_MODE(0), .OUT_REG(0), .CLEAR_VALUE(CV0)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .ready(rdy0),
        .we(we), .be(be), .write_addr(write_addr), .data_in(data_in),
        .re(re), .read_addr(read_addr), .data_out(dout0), .data_out_valid(vld0)
    );

    clr_sdp_ram #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
        .RDW_MODE(1), .OUT_REG(1), .CLEAR_VALUE(CV1)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .ready(rdy1),
        .we(we), .be(be), .write_addr(write_addr), .data_in(data_in),
        .re(re), .read_addr(read_addr), .data_out(dout1), .data_out_valid(vld1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s/%s observed=%h expected=%h", step, tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] b);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (b[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            exp0[i] = CV0;
            exp1[i] = CV1;
        end
    endtask

    // One clock cycle: drive inputs, advance the model, then check both outputs.
    task automatic cyc(input logic c, input logic w, input logic [3:0] b, input logic [3:0] wa,
                       input logic [31:0] d, input logic r, input logic [3:0] ra);
        logic [31:0] rd0, rd1;
        logic        acc_r;
        clear_req = c; we = w; be = b; write_addr = wa; data_in = d; re = r; read_addr = ra;
        acc_r = m_ready && r;
        rd0 = exp0[ra];
        rd1 = (m_ready && w && wa == ra) ? lane_merge(exp1[ra], d, b) : exp1[ra];
        e1_vld = e1a_vld;
        if (e1a_vld) e1_dat = e1a_dat;
        e1a_vld = acc_r;
        if (acc_r) e1a_dat = rd1;
        e0_vld = acc_r;
        if (acc_r) e0_dat = rd0;
        if (m_ready && w) begin
            exp0[wa] = lane_merge(exp0[wa], d, b);
            exp1[wa] = lane_merge(exp1[wa], d, b);
        end
        @(posedge clk); #1;
        chk("vld0", {31'b0, vld0}, {31'b0, e0_vld});
        chk("dout0", dout0, e0_dat);
        chk("vld1", {31'b0, vld1}, {31'b0, e1_vld});
        chk("dout1", dout1, e1_dat);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    endtask

    task automatic rd(input logic [3:0] a);
        cyc(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, a);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        cyc(1'b0, 1'b1, b, a, d, 1'b0, 4'h0);
    endtask

    // Runs a full sweep of 16 edges with we/re held high, checking ready timing.
    task automatic sweep(input logic pulse_clear_mid);
        m_ready = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cyc(pulse_clear_mid && k == 5, 1'b1, 4'hF, 4'(k - 1), 32'hFFFF_FFFF, 1'b1, 4'(k - 1));
            chk("rdy0", {31'b0, rdy0}, {31'b0, k == 16});
            chk("rdy1", {31'b0, rdy1}, {31'b0, k == 16});
        end
        m_ready = 1'b1;
        clear_model();
    endtask

    initial begin
        reset_n = 1'b0; clear_req = 1'b0; we = 1'b0; be = '0; write_addr = '0;
        data_in = '0; re = 1'b0; read_addr = '0;
        for (int i = 0; i < 16; i++) begin
            exp0[i] = 32'hxxxx_xxxx;
            exp1[i] = 32'hxxxx_xxxx;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rdy0", {31'b0, rdy0}, 32'd0);
        chk("vld0", {31'b0, vld0}, 32'd0);
        chk("dout0", dout0, 32'd0);
        chk("dout1", dout1, 32'd0);

        step = "init_sweep";
        reset_n = 1'b1;
        sweep(1'b0);

        step = "read_all_clear";
        for (int i = 0; i < 16; i++) rd(4'(i));
        idle(); idle();

        step = "lane_write";
        wr(4'd3, 32'hAABB_CCDD, 4'b1111);
        wr(4'd3, 32'h1122_3344, 4'b0101);
        rd(4'd3);
        chk("lat1_vld0", {31'b0, vld0}, 32'd1);
        chk("lat1_dout0", dout0, 32'hAA22_CC44);
        chk("lat2_vld1_low", {31'b0, vld1}, 32'd0);
        idle();
        chk("lat2_vld1", {31'b0, vld1}, 32'd1);
        chk("lat2_dout1", dout1, 32'hAA22_CC44);
        chk("hold_dout0", dout0, 32'hAA22_CC44);

        step = "rdw_full";
        cyc(1'b0, 1'b1, 4'hF, 4'd5, 32'hDEAD_BEEF, 1'b1, 4'd5);
        chk("old_dout0", dout0, 32'h0000_0000);
        idle();
        chk("new_dout1", dout1, 32'hDEAD_BEEF);

        step = "rdw_partial";
        cyc(1'b0, 1'b1, 4'b0011, 4'd6, 32'h1234_5678, 1'b1, 4'd6);
        chk("old_dout0", dout0, CV0);
        idle();
        chk("merged_dout1", dout1, 32'hA5A5_5678);

        step = "indep_and_be0";
        cyc(1'b0, 1'b1, 4'hF, 4'd7, 32'h0BAD_F00D, 1'b1, 4'd3);
        cyc(1'b0, 1'b1, 4'h0, 4'd3, 32'hFFFF_FFFF, 1'b1, 4'd3);
        rd(4'd7);
        idle();
        chk("be0_dout0", dout0, 32'h0BAD_F00D);
        chk("be0_dout1", dout1, 32'h0BAD_F00D);
        rd(4'd3);
        idle();
        chk("noop_dout1", dout1, 32'hAA22_CC44);

        step = "back_to_back";
        for (int i = 0; i < 8; i++) wr(4'(i), 32'h100 + 32'(i), 4'hF);
        for (int i = 0; i < 8; i++) rd(4'(i));
        idle(); idle();

        step = "clear_req";
        rd(4'd3);
        cyc(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
        sweep(1'b1);
        for (int i = 0; i < 16; i++) rd(4'(i));
        idle(); idle();

        step = "reset_mid_sweep";
        wr(4'd12, 32'h0000_0077, 4'hF);
        cyc(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
        m_ready = 1'b0;
        repeat (9) idle();
        reset_n = 1'b0;
        clear_req = 1'b0; we = 1'b0; re = 1'b0;
        @(posedge clk); #1;
        chk("rst_rdy0", {31'b0, rdy0}, 32'd0);
        chk("rst_vld0", {31'b0, vld0}, 32'd0);
        chk("rst_dout0", dout0, 32'd0);
        chk("rst_dout1", dout1, 32'd0);
        e0_vld = 1'b0; e0_dat = '0; e1a_vld = 1'b0; e1a_dat = '0; e1_vld = 1'b0; e1_dat = '0;
        reset_n = 1'b1;
        sweep(1'b0);
        rd(4'd12);
        rd(4'd15);
        idle(); idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
